// File: rtl/maze_update_rx_pkg.sv
// -----------------------------------------------------------------------------
// maze_update_rx_pkg
// Shared definitions for the maze array write-side producer: command codes,
// cell codes, grid size, FSM state encodings and the layout of the
// command/value nibble that closes every message.
// -----------------------------------------------------------------------------
package maze_update_rx_pkg;

  localparam int GRID_DIM = 16;

  // Command field of the third nibble.
  localparam logic [1:0] CMD_WRITE = 2'b00;
  localparam logic [1:0] CMD_CLEAR = 2'b01;

  // Cell codes stored in the maze array.
  localparam logic [1:0] CELL_UNEXPLORED = 2'b00;
  localparam logic [1:0] CELL_OPEN       = 2'b01;
  localparam logic [1:0] CELL_WALL       = 2'b10;
  localparam logic [1:0] CELL_TREASURE   = 2'b11;

  // Receiver FSM encodings.
  localparam logic [1:0] ST_WAIT_HI = 2'd0;
  localparam logic [1:0] ST_WAIT_LO = 2'd1;
  localparam logic [1:0] ST_WRITE   = 2'd2;
  localparam logic [1:0] ST_CLEAR   = 2'd3;

  // Third nibble of a message: {cmd[1:0], val[1:0]}.
  typedef struct packed {
    logic [1:0] cmd;
    logic [1:0] val;
  } cmd_nibble_t;

endpackage

// File: rtl/maze_update_rx_if.sv
// -----------------------------------------------------------------------------
// maze_update_rx_if
// 4-phase strobe/ack GPIO link between the Arduino and the maze receiver.
//   gpio_data   : nibble, held stable by the sender while the strobe is high
//   gpio_strobe : request from the sender
//   gpio_ack    : acknowledge from the receiver
// master = Arduino side, slave = FPGA receiver side.
// -----------------------------------------------------------------------------
interface maze_update_rx_if;
  logic [3:0] gpio_data;
  logic       gpio_strobe;
  logic       gpio_ack;

  modport master (output gpio_data, output gpio_strobe, input  gpio_ack);
  modport slave  (input  gpio_data, input  gpio_strobe, output gpio_ack);
endinterface

// File: rtl/maze_update_rx_gpio_sync.sv
// -----------------------------------------------------------------------------
// gpio_sync
// Parameterised multi-flop synchronizer for asynchronous GPIO inputs.
//   clk   : destination clock
//   reset : asynchronous active-low reset, clears every stage
//   d     : asynchronous input (WIDTH bits)
//   q     : synchronized output, STAGES clocks of latency
// -----------------------------------------------------------------------------
module gpio_sync
  import maze_update_rx_pkg::*;
#(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] ff;

  // NOTE: clocked state uses non-blocking assignments so every stage samples
  // the previous stage's old value; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ff <= '0;
    end else begin
      ff[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        ff[i] <= ff[i-1];
      end
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/maze_update_rx.sv
// -----------------------------------------------------------------------------
// maze_update_rx
// Receives 3-nibble cell updates over a 4-phase strobe/ack GPIO link and
// drives the maze array write port. Message: x, y, {cmd, val}.
// cmd 00 writes one cell, cmd 01 sweeps all 256 cells to 0, others set err.
//   clk     : system clock
//   reset   : asynchronous active-low reset
//   gpio    : GPIO link (slave side): data, strobe in; ack out
//   w_index : array write address {x, y}
//   value   : array write data
//   w_en    : array write enable, one clk per write
//   busy    : high during the clear sweep
//   err     : sticky, bad command or inter-nibble timeout seen
// -----------------------------------------------------------------------------
module maze_update_rx
  import maze_update_rx_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 25_000_000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  maze_update_rx_if.slave        gpio,
  output logic [7:0]             w_index,
  output logic [1:0]             value,
  output logic                   w_en,
  output logic                   busy,
  output logic                   err
);

  localparam int              TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic        strobe_s;
  logic [3:0]  data_s;

  logic [1:0]  state;
  logic [1:0]  nib_cnt;
  logic [3:0]  x_q;
  logic [3:0]  y_q;
  cmd_nibble_t n2_q;
  logic        ack_q;
  logic [TO_W-1:0] to_cnt;
  // Nine bits so the sweep terminates on 255 without relying on wrap-around.
  logic [8:0]  sweep;

  gpio_sync #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_sync_strobe (
    .clk   (clk),
    .reset (reset),
    .d     (gpio.gpio_strobe),
    .q     (strobe_s)
  );

  gpio_sync #(.STAGES(SYNC_STAGES), .WIDTH(4)) u_sync_data (
    .clk   (clk),
    .reset (reset),
    .d     (gpio.gpio_data),
    .q     (data_s)
  );

  assign gpio.gpio_ack = ack_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_WAIT_HI;
      nib_cnt <= 2'd0;
      x_q     <= '0;
      y_q     <= '0;
      n2_q    <= '0;
      ack_q   <= 1'b0;
      to_cnt  <= '0;
      sweep   <= '0;
      w_index <= '0;
      value   <= '0;
      w_en    <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      // Write enable defaults low; only WRITE and CLEAR raise it.
      w_en <= 1'b0;

      case (state)
        ST_WAIT_HI: begin
          if (strobe_s) begin
            case (nib_cnt)
              2'd0:    x_q  <= data_s;
              2'd1:    y_q  <= data_s;
              default: n2_q <= cmd_nibble_t'(data_s);
            endcase
            ack_q  <= 1'b1;
            to_cnt <= '0;
            state  <= ST_WAIT_LO;
          end else if (nib_cnt != 2'd0) begin
            // Partial message: give up after TIMEOUT_CYCLES idle cycles.
            if (to_cnt == TO_LAST) begin
              nib_cnt <= 2'd0;
              err     <= 1'b1;
              to_cnt  <= '0;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end else begin
            to_cnt <= '0;
          end
        end

        ST_WAIT_LO: begin
          if (!strobe_s) begin
            ack_q <= 1'b0;
            if (nib_cnt != 2'd2) begin
              nib_cnt <= nib_cnt + 2'd1;
              state   <= ST_WAIT_HI;
            end else begin
              nib_cnt <= 2'd0;
              case (n2_q.cmd)
                CMD_WRITE: state <= ST_WRITE;
                CMD_CLEAR: begin
                  state <= ST_CLEAR;
                  busy  <= 1'b1;
                  sweep <= '0;
                end
                default: begin
                  err   <= 1'b1;
                  state <= ST_WAIT_HI;
                end
              endcase
            end
          end
        end

        ST_WRITE: begin
          w_en    <= 1'b1;
          w_index <= {x_q, y_q};
          value   <= n2_q.val;
          state   <= ST_WAIT_HI;
        end

        default: begin  // ST_CLEAR
          w_en    <= 1'b1;
          value   <= CELL_UNEXPLORED;
          w_index <= sweep[7:0];
          if (sweep == 9'd255) begin
            busy  <= 1'b0;
            state <= ST_WAIT_HI;
          end else begin
            sweep <= sweep + 9'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_maze_update_rx.sv
// -----------------------------------------------------------------------------
// tb_maze_update_rx
// Drives 3-nibble messages over the 4-phase GPIO link and compares every
// array write against a message-level reference model (queue of expected
// {index, value} writes plus an expected err flag).
// -----------------------------------------------------------------------------
module tb_maze_update_rx;
  import maze_update_rx_pkg::*;

  localparam int TIMEOUT   = 100;
  localparam int ACK_BOUND = 600;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] w_index;
  logic [1:0] value;
  logic       w_en;
  logic       busy;
  logic       err;

  maze_update_rx_if bus ();

  maze_update_rx #(.TIMEOUT_CYCLES(TIMEOUT), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .gpio    (bus),
    .w_index (w_index),
    .value   (value),
    .w_en    (w_en),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model and observed write log, entries are {index, value}.
  logic [9:0] exp_q[$];
  logic [9:0] obs_q[$];
  logic       err_exp;
  int         busy_cnt;

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (w_en === 1'b1) obs_q.push_back({w_index, value});
      if (busy === 1'b1) busy_cnt++;
    end
  end

  // Expected effect of one complete message on the array.
  task automatic model_msg(input logic [3:0] x, input logic [3:0] y, input logic [3:0] n2);
    logic [1:0] cmd;
    cmd = n2[3:2];
    if (cmd == 2'b00) exp_q.push_back({x, y, n2[1:0]});
    else if (cmd == 2'b01) for (int i = 0; i < 256; i++) exp_q.push_back({8'(i), 2'b00});
    else err_exp = 1'b1;
  endtask

  function automatic int first_diff();
    int n;
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (obs_q[i] !== exp_q[i]) return i;
    if (obs_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.gpio_strobe = 1'b0;
    bus.gpio_data = 4'h0;
    wait_cycles(3);
    reset = 1'b1;
    exp_q.delete();
    obs_q.delete();
    err_exp = 1'b0;
    busy_cnt = 0;
    wait_cycles(2);
  endtask

  task automatic send_nibble(input logic [3:0] n);
    int k;
    @(negedge clk);
    bus.gpio_data = n;
    @(negedge clk);
    bus.gpio_strobe = 1'b1;
    k = 0;
    while (bus.gpio_ack !== 1'b1 && k < ACK_BOUND) begin @(negedge clk); k++; end
    n_checks++;
    if (bus.gpio_ack !== 1'b1) $display("FAIL ack_rise: ack=%b required 1 within %0d cycles (nibble %h)", bus.gpio_ack, ACK_BOUND, n);
    else n_pass++;
    bus.gpio_strobe = 1'b0;
    k = 0;
    while (bus.gpio_ack !== 1'b0 && k < ACK_BOUND) begin @(negedge clk); k++; end
    n_checks++;
    if (bus.gpio_ack !== 1'b0) $display("FAIL ack_fall: ack=%b required 0 within %0d cycles (nibble %h)", bus.gpio_ack, ACK_BOUND, n);
    else n_pass++;
  endtask

  task automatic send_msg(input logic [3:0] x, input logic [3:0] y, input logic [3:0] n2);
    model_msg(x, y, n2);
    send_nibble(x);
    send_nibble(y);
    send_nibble(n2);
  endtask

  task automatic check_log(input string name);
    int d;
    d = first_diff();
    n_checks++;
    if (d !== -1)
      $display("FAIL %s_log: entry %0d got %h required %h (got %0d writes, required %0d)", name, d,
               (d < obs_q.size()) ? obs_q[d] : 10'h3ff, (d < exp_q.size()) ? exp_q[d] : 10'h3ff,
               obs_q.size(), exp_q.size());
    else n_pass++;
    n_checks++;
    if (err !== err_exp) $display("FAIL %s_err: err=%b required %b", name, err, err_exp);
    else n_pass++;
  endtask

  task automatic test_reset();
    bus.gpio_strobe = 1'b0;
    bus.gpio_data = 4'h0;
    reset = 1'b0;
    wait_cycles(2);
    n_checks++;
    if ({bus.gpio_ack, w_en, w_index, value, busy, err} !== 14'h0)
      $display("FAIL reset_outputs: ack,w_en,idx,val,busy,err=%b required all 0",
               {bus.gpio_ack, w_en, w_index, value, busy, err});
    else n_pass++;
    apply_reset();
  endtask

  task automatic test_write();
    apply_reset();
    send_msg(4'h3, 4'h5, {CMD_WRITE, CELL_WALL});
    wait_cycles(8);
    check_log("write");
  endtask

  task automatic test_clear();
    int k;
    int ack_in_busy;
    apply_reset();
    send_msg(4'hA, 4'h6, {CMD_CLEAR, 2'b00});
    wait_cycles(50);
    // Start the next message mid-sweep; it must stall until busy falls.
    bus.gpio_data = 4'h9;
    @(negedge clk);
    bus.gpio_strobe = 1'b1;
    ack_in_busy = 0;
    k = 0;
    while (busy === 1'b1 && k < ACK_BOUND) begin
      if (bus.gpio_ack === 1'b1) ack_in_busy++;
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (ack_in_busy !== 0) $display("FAIL clear_ack_stall: ack high %0d cycles during sweep, required 0", ack_in_busy);
    else n_pass++;
    n_checks++;
    if (busy_cnt !== 256) $display("FAIL clear_busy_len: busy high %0d cycles, required 256", busy_cnt);
    else n_pass++;
    k = 0;
    while (bus.gpio_ack !== 1'b1 && k < ACK_BOUND) begin @(negedge clk); k++; end
    n_checks++;
    if (bus.gpio_ack !== 1'b1) $display("FAIL clear_late_ack: ack=%b required 1 after sweep", bus.gpio_ack);
    else n_pass++;
    bus.gpio_strobe = 1'b0;
    k = 0;
    while (bus.gpio_ack !== 1'b0 && k < ACK_BOUND) begin @(negedge clk); k++; end
    model_msg(4'h9, 4'h1, {CMD_WRITE, CELL_TREASURE});
    send_nibble(4'h1);
    send_nibble({CMD_WRITE, CELL_TREASURE});
    wait_cycles(8);
    check_log("clear");
  endtask

  task automatic test_invalid();
    apply_reset();
    send_msg(4'h1, 4'h2, 4'b1101);
    wait_cycles(8);
    check_log("invalid");
    send_msg(4'h4, 4'h4, {CMD_WRITE, CELL_OPEN});
    wait_cycles(8);
    check_log("after_invalid");
  endtask

  task automatic test_timeout();
    apply_reset();
    send_nibble(4'h7);
    wait_cycles(TIMEOUT / 2);
    n_checks++;
    if (err !== 1'b0) $display("FAIL timeout_early: err=%b required 0 at half timeout", err);
    else n_pass++;
    wait_cycles(TIMEOUT / 2 + 30);
    err_exp = 1'b1;
    check_log("timeout");
    send_msg(4'h2, 4'h9, {CMD_WRITE, CELL_TREASURE});
    wait_cycles(8);
    check_log("after_timeout");
  endtask

  task automatic test_reset_mid_clear();
    int k;
    apply_reset();
    send_msg(4'h0, 4'h0, {CMD_CLEAR, 2'b00});
    k = 0;
    while (!(w_en === 1'b1 && w_index === 8'd100) && k < ACK_BOUND) begin @(negedge clk); k++; end
    n_checks++;
    if (!(w_en === 1'b1 && w_index === 8'd100)) $display("FAIL midclear_reach: w_en=%b idx=%0d required 1/100", w_en, w_index);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({w_en, busy, bus.gpio_ack} !== 3'b000) $display("FAIL midclear_reset: w_en,busy,ack=%b required 000", {w_en, busy, bus.gpio_ack});
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    obs_q.delete();
    err_exp = 1'b0;
    wait_cycles(2);
    send_msg(4'h0, 4'h0, {CMD_WRITE, CELL_OPEN});
    wait_cycles(8);
    check_log("midclear_after");
  endtask

  task automatic test_back_to_back();
    logic [3:0] r;
    apply_reset();
    for (int m = 0; m < 24; m++) begin
      r = 4'($urandom_range(0, 7));
      // Mostly writes, occasionally invalid commands 10/11.
      send_msg(4'($urandom), 4'($urandom), {(r < 4'd6) ? 2'b00 : r[1:0] ^ 2'b00 | 2'b10, 2'($urandom)});
    end
    // A repeated cell: last write must be the one recorded last.
    send_msg(4'hC, 4'hD, {CMD_WRITE, CELL_OPEN});
    send_msg(4'hC, 4'hD, {CMD_WRITE, CELL_WALL});
    wait_cycles(8);
    check_log("back_to_back");
  endtask

  initial begin
    err_exp = 1'b0;
    busy_cnt = 0;
    test_reset();
    test_write();
    test_clear();
    test_invalid();
    test_timeout();
    test_reset_mid_clear();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/maze_update_rx.md
Name: maze_update_rx

Overview:
- Write-side producer for the maze block array.
- Receives cell updates from the Arduino over a 4-bit GPIO bus with a 4-phase strobe/ack handshake, assembles 3-nibble messages, and drives the array write port (w_index, value, w_en).
- Also supports a clear-all command that sweeps all 256 cells to 0.
- Sits between the GPIO pins and the array write port. The VGA renderer owns the array read port.

Parameters:
- TIMEOUT_CYCLES, 25000000: idle cycles allowed between nibbles of one message before the partial message is discarded (1 s at 25 MHz).
- SYNC_STAGES, 2: synchronizer flops on gpio_strobe and gpio_data.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- gpio_data  in  4  nibble from Arduino (asynchronous)
- gpio_strobe  in  1  Arduino request (asynchronous)
- gpio_ack  out  1  acknowledge to Arduino
- w_index  out  8  array write address, {x[3:0], y[3:0]}
- value  out  2  array write data
- w_en  out  1  array write enable, one clk per write
- busy  out  1  high during the clear sweep
- err  out  1  sticky: bad command or timeout seen

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-low.
- Reset values: gpio_ack=0, w_en=0, w_index=0, value=0, busy=0, err=0, nib_cnt=0, state=WAIT_HI, sync flops=0.
- Synchronization: gpio_strobe and gpio_data each pass through SYNC_STAGES flops. Only synchronized versions are used. The Arduino holds data stable while the strobe is high.
- Message format:
  - nibble0 = x
  - nibble1 = y
  - nibble2 = {cmd[1:0], val[1:0]}
  - cmd 00 = write cell; cmd 01 = clear all; cmd 10/11 = invalid.
- FSM states: WAIT_HI, WAIT_LO, WRITE, CLEAR.
  - WAIT_HI:
    - When the synced strobe is 1: latch the synced nibble into slot nib_cnt, set gpio_ack=1, go to WAIT_LO.
    - Else, if nib_cnt!=0, increment the timeout counter. At TIMEOUT_CYCLES: nib_cnt=0, err=1.
    - The timeout counter clears on every accepted nibble and whenever nib_cnt==0.
  - WAIT_LO:
    - Hold ack until the synced strobe is 0, then set gpio_ack=0.
    - If nib_cnt<2: nib_cnt+1, go to WAIT_HI.
    - If nib_cnt==2: nib_cnt=0, then dispatch:
      - cmd 00 -> WRITE
      - cmd 01 -> CLEAR, with busy=1 and sweep index=0
      - otherwise err=1, go to WAIT_HI
  - WRITE:
    - w_en=1 for exactly one cycle, w_index={x,y}, value=val. Then go to WAIT_HI.
    - Latency: w_en asserts on the 2nd clk edge after the synced strobe is seen low.
  - CLEAR:
    - Drive w_en=1 and value=0 every cycle, with w_index = 0,1,...,255 on consecutive cycles (256 cycles).
    - After index 255: busy=0, w_en=0, go to WAIT_HI.
    - The index counter is 9 bits internally so that 255 terminates cleanly and does not wrap back to 0.
    - gpio_ack stays 0 throughout. A strobe arriving during CLEAR is serviced only after CLEAR exits; the Arduino stalls naturally.
- w_en is 0 in every cycle not listed above. w_index and value hold their last values when w_en=0.
- Repeated messages: a write to the same cell twice is legal; the last one wins.
- Clearing err: only reset clears err.
- Reset mid-operation (mid-message or mid-CLEAR): all state returns to reset values immediately. A partial sweep is not resumed.
- Strobe glitch: a synced strobe shorter than 1 cycle is never seen. Any synced high of at least 1 cycle counts as one nibble.

Decomposition:
- Shared maze package holds:
  - CMD_WRITE=2'b00, CMD_CLEAR=2'b01
  - cell codes (2'b00 unexplored, 2'b01 open, 2'b10 wall, 2'b11 treasure)
  - GRID_DIM=16
  - the FSM state encodings
- One sub-module, gpio_sync: a parameterised N-flop synchronizer, instantiated for the strobe and for the 4 data bits.

Test Plan:
- Write cell: nibbles 3,5,{00,10}, each with a full 4-phase handshake -> exactly one w_en pulse with w_index=8'h35, value=2'b10; gpio_ack tracks each strobe; err=0.
- Clear all: nibbles x,x,{01,00} -> busy=1 for 256 cycles, w_en=1 with w_index 0..255 contiguous and value=0, then busy=0. A strobe raised mid-sweep gets no ack until busy falls.
- Invalid command: nibbles 1,2,{11,01} -> no w_en, err=1. A following valid message 4,4,{00,01} still writes 8'h44=01.
- Timeout: send nibble 7, then idle TIMEOUT_CYCLES (override to 100) -> err=1, nib_cnt=0. The next three nibbles 2,9,{00,11} write 8'h29=11.
- Reset mid-CLEAR: assert reset at sweep index 100 -> w_en=0, busy=0 immediately. After release, a write message 0,0,{00,01} completes normally.
- Back-to-back messages with minimal strobe gaps (synchronizer latency only) -> every message produces exactly one correct write; none dropped or duplicated.
